// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive controller: synchronizer, mid-bit sampling FSM and receive buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_rx_ctrl #(
    parameter int DIVISOR    = 10416,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_full,
    output logic       busy,
    output logic       overrun,
    output logic       frame_err,
    output logic       irq
);

    localparam int CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIVISOR - 1);

    if (DIVISOR < 8) begin : g_bad_divisor
        $error("uart_rx_ctrl: DIVISOR must be at least 8");
    end
    if ((FIFO_DEPTH < 1) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_rx_ctrl: FIFO_DEPTH must be a power of two");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bidx_reg, bidx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          sync1_reg, sync2_reg;
    logic          overrun_reg, frame_err_reg;
    logic          push_req, frame_set;
    logic          push, pop, overrun_set;
    logic          rx_s;

    assign rx_s = sync2_reg;

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bidx_reg  <= '0;
            shift_reg <= '0;
        end else begin
            sync1_reg <= UART_RX;
            sync2_reg <= sync1_reg;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bidx_reg  <= bidx_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bidx_next  = bidx_reg;
        shift_next = shift_reg;
        push_req   = 1'b0;
        frame_set  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                // A start bit that is high again at its midpoint is treated as line noise.
                if (cnt_reg == HALF_LAST) begin
                    cnt_next  = '0;
                    bidx_next = '0;
                    state_next = rx_s ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    shift_next = {rx_s, shift_reg[7:1]};
                    cnt_next   = '0;
                    if (bidx_reg == 3'd7)
                        state_next = STOP;
                    else
                        bidx_next = bidx_reg + 3'd1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    push_req   = rx_s;
                    frame_set  = !rx_s;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A pop on the same edge frees the slot, so a full buffer can still accept the byte.
    assign pop         = rd_en && rx_valid;
    assign push        = push_req && (!rx_full || pop);
    assign overrun_set = push_req && rx_full && !pop;

`ifdef UART_RX_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    if (FIFO_DEPTH < 2) begin : g_bad_fifo_depth
        $error("uart_rx_ctrl: FIFO_DEPTH must be at least 2 with the FIFO enabled");
    end

    logic [AW:0]           wr_ptr_reg, rd_ptr_reg;
    logic [7:0]            mem_reg [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] wr_sel;

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_sel
        assign wr_sel[gi] = push && (wr_ptr_reg[AW-1:0] == AW'(gi));
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_reg[i] <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                if (wr_sel[i])
                    mem_reg[i] <= shift_reg;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    assign rx_valid = (wr_ptr_reg != rd_ptr_reg);
    assign rx_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign rx_data  = mem_reg[rd_ptr_reg[AW-1:0]];
`else
    logic [7:0] hold_reg;
    logic       hold_valid_reg;

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
        end else begin
            if (push) begin
                hold_reg       <= shift_reg;
                hold_valid_reg <= 1'b1;
            end else if (pop) begin
                hold_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_valid = hold_valid_reg;
    assign rx_full  = hold_valid_reg;
    assign rx_data  = hold_reg;
`endif

    // Setting a flag takes priority over clearing it on the same edge.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            if (overrun_set)
                overrun_reg <= 1'b1;
            else if (clr_err)
                overrun_reg <= 1'b0;
            if (frame_set)
                frame_err_reg <= 1'b1;
            else if (clr_err)
                frame_err_reg <= 1'b0;
        end
    end

    assign overrun   = overrun_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != IDLE);
    assign irq       = rx_valid | overrun_reg | frame_err_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: serial frames driven bit by bit, checked against a queue model of the buffer.
// Buffer depth follows UART_RX_FIFO_EN exactly as the design does.
module tb_uart_rx_ctrl;

    localparam int DIV = 16;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    // Pin falls after edge 0; 2 sync edges + 1 state edge, then half a bit and 9 full bits.
    localparam int STOP_EDGE = 3 + DIV / 2 + 9 * DIV;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       UART_RX;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rx_data;
    logic       rx_valid, rx_full, busy, overrun, frame_err, irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic       ovr_m = 1'b0;
    logic       fe_m  = 1'b0;
    int         rise_edge;

    uart_rx_ctrl #(.DIVISOR(DIV), .FIFO_DEPTH(4)) dut (
        .sysclk(sysclk), .reset(reset), .UART_RX(UART_RX), .rd_en(rd_en), .clr_err(clr_err),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full), .busy(busy),
        .overrun(overrun), .frame_err(frame_err), .irq(irq)
    );

    always #5 sysclk = ~sysclk;

    task automatic idle(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // Drives one frame; optionally holds rd_en for exactly the edge numbered pop_edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_edge);
        logic [9:0] fr;
        logic       prev_v;
        fr = {stop, b, 1'b0};
        prev_v = rx_valid;
        rise_edge = -1;
        for (int i = 0; i < 10 * DIV; i++) begin
            if (i % DIV == 0) UART_RX = fr[i / DIV];
            if (pop_edge > 0) rd_en = (i == pop_edge - 1);
            @(posedge sysclk);
            #1;
            if (rx_valid && !prev_v && rise_edge < 0) rise_edge = i + 1;
            prev_v = rx_valid;
        end
        UART_RX = 1'b1;
        if (pop_edge > 0) rd_en = 1'b0;
        if (pop_edge > 0 && q.size() > 0) void'(q.pop_front());
        if (stop) begin
            if (q.size() < DEPTH) q.push_back(b);
            else ovr_m = 1'b1;
        end else begin
            fe_m = 1'b1;
        end
        $display("frame %02h stop %0b pop_edge %0d queued %0d", b, stop, pop_edge, q.size());
    endtask

    task automatic pop_byte(output logic [7:0] got, output logic was_valid);
        was_valid = rx_valid;
        got = rx_data;
        rd_en = 1'b1;
        @(posedge sysclk);
        #1;
        rd_en = 1'b0;
        $display("read %02h valid %0b", got, was_valid);
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        @(posedge sysclk);
        #1;
        clr_err = 1'b0;
        ovr_m = 1'b0;
        fe_m = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            rd_en = 1'b1;
            @(posedge sysclk);
            #1;
        end
        rd_en = 1'b0;
        q.delete();
        clear_flags();
    endtask

    task automatic test_reset();
        reset = 1'b0; UART_RX = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        idle(3);
        checks++; if ({rx_valid, rx_full, busy, overrun, frame_err, irq} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 000000", {rx_valid, rx_full, busy, overrun, frame_err, irq}); end
        checks++; if (rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_data got %02h exp 00", rx_data); end
        reset = 1'b1;
        idle(4);
    endtask

    task automatic test_basic();
        logic [7:0] got; logic v;
        send_frame(8'h55, 1'b1, 0);
        checks++; if (rise_edge !== STOP_EDGE) begin
            errors++; $display("FAIL basic_latency got %0d exp %0d", rise_edge, STOP_EDGE); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin
            errors++; $display("FAIL basic_data got v%b %02h exp v1 55", rx_valid, rx_data); end
        pop_byte(got, v);
        void'(q.pop_front());
        checks++; if (rx_valid !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL basic_pop got valid %b irq %b exp 0 0", rx_valid, irq); end
    endtask

    task automatic test_overrun();
        logic [7:0] got; logic v;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            send_frame(8'(k), 1'b1, 0);
            if (k == DEPTH) begin
                checks++; if (rx_full !== 1'b1 || overrun !== 1'b0) begin
                    errors++; $display("FAIL ovr_full got full %b ovr %b exp 1 0", rx_full, overrun); end
            end
        end
        checks++; if (overrun !== 1'b1 || irq !== 1'b1) begin
            errors++; $display("FAIL ovr_flag got ovr %b irq %b exp 1 1", overrun, irq); end
        for (int k = 1; k <= DEPTH; k++) begin
            pop_byte(got, v);
            void'(q.pop_front());
            checks++; if (v !== 1'b1 || got !== 8'(k)) begin
                errors++; $display("FAIL ovr_order got v%b %02h exp v1 %02h", v, got, 8'(k)); end
        end
        checks++; if (rx_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_after got valid %b ovr %b exp 0 1", rx_valid, overrun); end
        clear_flags();
        checks++; if (overrun !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL ovr_clear got ovr %b irq %b exp 0 0", overrun, irq); end
    endtask

    task automatic test_frame_err();
        send_frame(8'hA3, 1'b0, 0);
        idle(2 * DIV);
        checks++; if (frame_err !== 1'b1 || irq !== 1'b1 || rx_valid !== 1'b0) begin
            errors++; $display("FAIL ferr_set got fe %b irq %b valid %b exp 1 1 0", frame_err, irq, rx_valid); end
        checks++; if (busy !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL ferr_idle got busy %b ovr %b exp 0 0", busy, overrun); end
        clear_flags();
        checks++; if (frame_err !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL ferr_clear got fe %b irq %b exp 0 0", frame_err, irq); end
    endtask

    task automatic test_glitch();
        UART_RX = 1'b0;
        idle(4);
        UART_RX = 1'b1;
        checks++; if (busy !== 1'b1) begin
            errors++; $display("FAIL glitch_busy got %b exp 1", busy); end
        idle(2 * DIV);
        checks++; if ({busy, rx_valid, overrun, frame_err, irq} !== 5'b0) begin
            errors++; $display("FAIL glitch_idle got %b exp 00000", {busy, rx_valid, overrun, frame_err, irq}); end
        $display("glitch pulse of 4 cycles");
    endtask

    task automatic test_pop_on_stop();
        logic [7:0] got; logic v; logic [7:0] exp_b;
        for (int k = 0; k < DEPTH; k++) send_frame(8'($urandom_range(0, 255)), 1'b1, 0);
        send_frame(8'h7E, 1'b1, STOP_EDGE);
        checks++; if (overrun !== 1'b0 || rx_full !== 1'b1) begin
            errors++; $display("FAIL pos_flags got ovr %b full %b exp 0 1", overrun, rx_full); end
        for (int k = 0; k < DEPTH; k++) begin
            exp_b = q.pop_front();
            pop_byte(got, v);
            checks++; if (v !== 1'b1 || got !== exp_b) begin
                errors++; $display("FAIL pos_data got v%b %02h exp v1 %02h", v, got, exp_b); end
        end
        checks++; if (got !== 8'h7E || rx_valid !== 1'b0) begin
            errors++; $display("FAIL pos_last got %02h valid %b exp 7e 0", got, rx_valid); end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] fr; logic [7:0] got; logic v;
        send_frame(8'h99, 1'b1, 0);
        fr = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 5 * DIV + DIV / 2; i++) begin
            if (i % DIV == 0) UART_RX = fr[i / DIV];
            @(posedge sysclk);
            #1;
        end
        reset = 1'b0;
        UART_RX = 1'b1;
        idle(1);
        q.delete(); ovr_m = 1'b0; fe_m = 1'b0;
        checks++; if ({rx_valid, rx_full, busy, overrun, frame_err, irq} !== 6'b0 || rx_data !== 8'h00) begin
            errors++; $display("FAIL rst_mid got %b data %02h exp 000000 00",
                               {rx_valid, rx_full, busy, overrun, frame_err, irq}, rx_data); end
        idle(2);
        reset = 1'b1;
        idle(4);
        send_frame(8'hC3, 1'b1, 0);
        pop_byte(got, v);
        void'(q.pop_front());
        checks++; if (v !== 1'b1 || got !== 8'hC3 || frame_err !== 1'b0) begin
            errors++; $display("FAIL rst_after got v%b %02h fe %b exp v1 c3 0", v, got, frame_err); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got; logic v; logic [7:0] exp_b;
        for (int k = 0; k < 3; k++) send_frame(8'($urandom_range(0, 255)), 1'b1, 0);
        checks++; if (overrun !== ovr_m || rx_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_flags got ovr %b valid %b exp %b 1", overrun, rx_valid, ovr_m); end
        while (q.size() > 0) begin
            exp_b = q.pop_front();
            pop_byte(got, v);
            checks++; if (v !== 1'b1 || got !== exp_b) begin
                errors++; $display("FAIL b2b_data got v%b %02h exp v1 %02h", v, got, exp_b); end
        end
        clear_flags();
    endtask

    task automatic test_random();
        logic [7:0] b, got, exp_b; logic stop, v; int pe;
        for (int it = 0; it < 14; it++) begin
            b = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            pe = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, STOP_EDGE)) : 0;
            send_frame(b, stop, pe);
            if (!stop) idle(2 * DIV);
            checks++; if (rx_valid !== (q.size() > 0) || rx_full !== (q.size() == DEPTH)) begin
                errors++; $display("FAIL rnd_level it %0d got v%b f%b exp v%b f%b", it, rx_valid, rx_full,
                                   q.size() > 0, q.size() == DEPTH); end
            checks++; if (overrun !== ovr_m || frame_err !== fe_m || irq !== ((q.size() > 0) | ovr_m | fe_m)) begin
                errors++; $display("FAIL rnd_flags it %0d got o%b e%b i%b exp o%b e%b", it, overrun, frame_err,
                                   irq, ovr_m, fe_m); end
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                exp_b = q.pop_front();
                pop_byte(got, v);
                checks++; if (v !== 1'b1 || got !== exp_b) begin
                    errors++; $display("FAIL rnd_data it %0d got v%b %02h exp v1 %02h", it, v, got, exp_b); end
            end
            if ($urandom_range(0, 3) == 0) clear_flags();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_pop_on_stop();
        test_reset_mid_frame();
        drain();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
